// File: rtl/clock_freq_meter.sv
// ---------------------------------------------------------------------------
// clock_freq_meter
//
// Counts rising edges of an asynchronous input (typically one divided-clock
// output of the ripple divider) over a fixed window of GATE_CYCLES clk
// cycles. The input passes through a three-flop synchroniser. A rise is
// s2 & ~s3. The result is published with a one-cycle done pulse.
//
// Ports:
//   clk        system clock; all state updates on its rising edge
//   reset      synchronous, active-high reset
//   sig_in     signal under measurement, asynchronous to clk
//   start      begin a measurement; sampled only while idle
//   busy       high whenever a measurement is running or being published
//   done       one-cycle pulse when edge_count/overflow are updated
//   edge_count rising edges counted in the last completed window
//   overflow   last window's count saturated at 2^CNT_W-1
// ---------------------------------------------------------------------------
module clock_freq_meter #(
  parameter int GATE_CYCLES = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] acc_q;
  logic             sat_q;
  logic [CNT_W-1:0] edge_count_q;
  logic             overflow_q;

  logic             rise;
  logic             acc_at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] acc_d;
  logic             gate_end;

  // s1 may go metastable; s2/s3 are the settled copies used for detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating accumulate: a rise on a full accumulator is lost but recorded.
  assign acc_at_max = (acc_q == CNT_MAX);
  assign sat_hit    = rise & acc_at_max;
  assign acc_d      = (rise && !acc_at_max) ? acc_q + 1'b1 : acc_q;
  assign gate_end   = (gate_q == GATE_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_MEASURE;
      S_MEASURE: if (gate_end) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_MEASURE: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Window datapath. The last gate edge folds in its own rise so that a
  // window covers exactly GATE_CYCLES samples of the rise signal.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q       <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            gate_q <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
          end
        end
        S_MEASURE: begin
          gate_q <= gate_q + 1'b1;
          acc_q  <= acc_d;
          sat_q  <= sat_q | sat_hit;
          if (gate_end) begin
            edge_count_q <= acc_d;
            overflow_q   <= sat_q | sat_hit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_clock_freq_meter.sv
// ---------------------------------------------------------------------------
// Bench for clock_freq_meter. Two instances share sig_in: dut (CNT_W=16)
// and dut4 (CNT_W=4, for saturation). Stimulus pushes the expected result
// and the expected done cycle into a queue per instance; a monitor per
// instance pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_clock_freq_meter;

  localparam int GATE = 256;

  typedef struct {
    int cnt;
    int ovf;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        busy, done, overflow;
  logic [15:0] edge_count;
  logic        busy4, done4, overflow4;
  logic [3:0]  edge_count4;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   sig_half = 4;
  logic sig_level = 1'b0;
  exp_t q16[$];
  exp_t q4[$];

  clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .edge_count(edge_count), .overflow(overflow)
  );

  clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start4),
    .busy(busy4), .done(done4), .edge_count(edge_count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cycle %0d actual %0d required %0d", nm, cyc, act, exp);
    end
  endtask

  // clk-synchronous square wave, half period sig_half; 0 means hold sig_level
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      if (sig_half == 0) begin
        sig_in = sig_level;
        ph = 0;
      end else if (ph >= sig_half - 1) begin
        sig_in = ~sig_in;
        ph = 0;
      end else begin
        ph++;
      end
    end
  end

  // Monitors
  always @(negedge clk) begin
    if (done) begin
      if (q16.size() == 0) begin
        chk("dut16_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("dut16_done_cycle", cyc, e.cyc);
        chk("dut16_edge_count", int'(edge_count), e.cnt);
        chk("dut16_overflow", int'(overflow), e.ovf);
        $display("dut16 result cycle %0d count %0d ovf %0d", cyc, edge_count, overflow);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("dut4_done_cycle", cyc, e.cyc);
        chk("dut4_edge_count", int'(edge_count4), e.cnt);
        chk("dut4_overflow", int'(overflow4), e.ovf);
        $display("dut4 result cycle %0d count %0d ovf %0d", cyc, edge_count4, overflow4);
      end
    end
  end

  // Wait (bounded) until the given queue drains.
  task automatic wait_drain(input bit is4, input int budget);
    int n = 0;
    while ((is4 ? q4.size() : q16.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((is4 ? q4.size() : q16.size()) != 0) begin
      chk(is4 ? "dut4_timeout" : "dut16_timeout", 1, 0);
      if (is4) q4.delete(); else q16.delete();
    end
  endtask

  // One measurement; the instance is known idle at entry.
  task automatic run(input bit is4, input int cnt, input int ovf);
    exp_t e;
    @(negedge clk);
    if (is4) start4 = 1'b1; else start = 1'b1;
    e.cnt = cnt;
    e.ovf = ovf;
    e.cyc = cyc + 1 + GATE;
    if (is4) q4.push_back(e); else q16.push_back(e);
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
    chk(is4 ? "dut4_busy_after_start" : "dut16_busy_after_start",
        int'(is4 ? busy4 : busy), 1);
    wait_drain(is4, GATE + 20);
    @(negedge clk);
    chk(is4 ? "dut4_idle_after_done" : "dut16_idle_after_done",
        int'(is4 ? busy4 : busy), 0);
  endtask

  initial begin
    int t;
    // Reset with sig_in toggling
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_edge_count", int'(edge_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    repeat (10) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_edge_count", int'(edge_count), 0);

    // Period 8 -> 32
    run(1'b0, 32, 0);
    // Period 2 -> 128
    sig_half = 1;
    repeat (5) @(negedge clk);
    run(1'b0, 128, 0);
    // Held low / held high -> 0
    sig_half = 0; sig_level = 1'b0;
    repeat (5) @(negedge clk);
    run(1'b0, 0, 0);
    sig_level = 1'b1;
    repeat (5) @(negedge clk);
    run(1'b0, 0, 0);

    // 4-bit counter: period 8 saturates, period 32 -> 8
    sig_half = 4;
    repeat (5) @(negedge clk);
    run(1'b1, 15, 1);
    sig_half = 16;
    repeat (5) @(negedge clk);
    run(1'b1, 8, 0);

    // start held high: back-to-back windows every GATE+2 cycles
    sig_half = 4;
    repeat (5) @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.cnt = 32; e.ovf = 0; e.cyc = t + GATE + i * (GATE + 2);
      q16.push_back(e);
    end
    wait_drain(1'b0, 3 * (GATE + 2) + 20);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_idle", int'(busy), 0);

    // Reset 100 cycles into a window: nothing published, outputs cleared
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_edge_count", int'(edge_count), 0);
    chk("abort_overflow", int'(overflow), 0);
    repeat (GATE + 20) @(negedge clk);
    chk("abort_still_idle", int'(busy), 0);
    run(1'b0, 32, 0);

    chk("dut16_queue_empty", q16.size(), 0);
    chk("dut4_queue_empty", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
